// File: rtl/gf2_exact_div_binomial_pkg.sv
// Shared types and helpers for the GF(2)[x] exact binomial divider.
package gf2_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_t;

  // One guard bit above the exponent width lets off reach N without wrapping.
  localparam int OFF_GUARD_W = 1;

  function automatic int f_off_w(input int ew);
    return ew + OFF_GUARD_W;
  endfunction

  function automatic int f_terms(input int n, input int a, input int d);
    if (d <= 0 || a >= n) return 0;
    return (n - a + d - 1) / d;
  endfunction

  function automatic int f_cycles(input int n, input int a, input int d, input int lanes);
    return (f_terms(n, a, d) + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/gf2_exact_div_binomial_lanes.sv
// XOR of LANES right-shifted copies of the dividend at off, off+D, off+2D, ...
module gf2_shift_xor_lanes
  import gf2_div_pkg::*;
#(
  parameter int N     = 4460,
  parameter int LANES = 2,
  parameter int EW    = $clog2(N),
  parameter int OW    = EW + 1
) (
  input  logic [N-1:0]  p_reg,
  input  logic [OW-1:0] off,
  input  logic [EW-1:0] d,
  output logic [N-1:0]  terms
);

  localparam int SW = OW + $clog2(LANES) + 2;
  localparam logic [SW-1:0] N_SW = SW'(N);

  logic [SW-1:0] sh [LANES];

  always_comb begin
    terms = '0;
    for (int j = 0; j < LANES; j++) begin
      sh[j] = SW'(off) + SW'(j) * SW'(d);
      // Shifts at or beyond N would contribute nothing; skip them explicitly.
      if (sh[j] < N_SW) terms = terms ^ (p_reg >> sh[j]);
    end
  end

endmodule

// File: rtl/gf2_exact_div_binomial.sv
// Sequential exact divider q = p / (x^A + x^B) over GF(2)[x], LANES terms per cycle.
module gf2_exact_div_binomial
  import gf2_div_pkg::*;
#(
  parameter int N     = 4460,
  parameter int LANES = 2,
  parameter int EW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [EW-1:0] a_exp,
  input  logic [EW-1:0] b_exp,
  input  logic [N-1:0]  p,
  output logic          busy,
  output logic [N-1:0]  q,
  output logic          done,
  output logic          exact,
  output logic          err
);

  localparam int OW = f_off_w(EW);
  localparam int SW = OW + $clog2(LANES) + 2;
  localparam logic [OW-1:0] N_OFF    = OW'(N);
  localparam logic [SW-1:0] N_SW     = SW'(N);
  localparam logic [SW-1:0] LANES_SW = SW'(LANES);

  state_t        state, state_n;
  logic [N-1:0]  p_reg, p_n;
  logic [EW-1:0] a_reg, a_n;
  logic [EW-1:0] b_reg, b_n;
  logic [EW-1:0] d_reg, d_n;
  logic [OW-1:0] off, off_n;
  logic [N-1:0]  q_n;
  logic          done_n, exact_n, err_n;

  logic [N-1:0]  lane_terms;
  logic [OW-1:0] off_step;
  logic          params_ok;
  logic          check_ok;

  // Advance the offset by LANES*D, clamping at N so it can never wrap.
  function automatic logic [OW-1:0] f_sat_off(input logic [OW-1:0] cur,
                                             input logic [EW-1:0] d);
    logic [SW-1:0] sum;
    sum = SW'(cur) + LANES_SW * SW'(d);
    return (sum >= N_SW) ? N_OFF : sum[OW-1:0];
  endfunction

  // q*(x^A+x^B) must reproduce p in the low N bits and spill nothing above.
  function automatic logic f_exact(input logic [N-1:0]  qv,
                                   input logic [N-1:0]  pv,
                                   input logic [EW-1:0] av,
                                   input logic [EW-1:0] bv);
    logic [N-1:0]  lo;
    logic [N-1:0]  hi;
    logic [OW-1:0] hs;
    lo = (qv << av) ^ (qv << bv);
    hs = N_OFF - {1'b0, av};
    hi = qv >> hs;
    return (lo == pv) && (hi == '0);
  endfunction

  gf2_shift_xor_lanes #(
    .N     (N),
    .LANES (LANES),
    .EW    (EW),
    .OW    (OW)
  ) u_lanes (
    .p_reg (p_reg),
    .off   (off),
    .d     (d_reg),
    .terms (lane_terms)
  );

  assign off_step  = f_sat_off(off, d_reg);
  assign params_ok = (a_exp > b_exp) && ({1'b0, a_exp} < N_OFF);
  assign check_ok  = f_exact(q, p_reg, a_reg, b_reg);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    p_n     = p_reg;
    a_n     = a_reg;
    b_n     = b_reg;
    d_n     = d_reg;
    off_n   = off;
    q_n     = q;
    done_n  = 1'b0;
    exact_n = exact;
    err_n   = err;
    case (state)
      IDLE: begin
        if (start) begin
          q_n     = '0;
          exact_n = 1'b0;
          if (params_ok) begin
            p_n     = p;
            a_n     = a_exp;
            b_n     = b_exp;
            d_n     = a_exp - b_exp;
            off_n   = {1'b0, a_exp};
            err_n   = 1'b0;
            state_n = RUN;
          end else begin
            err_n  = 1'b1;
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        q_n   = q ^ lane_terms;
        off_n = off_step;
        if (off_step >= N_OFF) state_n = CHECK;
      end
      CHECK: begin
        exact_n = check_ok;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      p_reg <= '0;
      a_reg <= '0;
      b_reg <= '0;
      d_reg <= '0;
      off   <= '0;
      q     <= '0;
      done  <= 1'b0;
      exact <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      p_reg <= p_n;
      a_reg <= a_n;
      b_reg <= b_n;
      d_reg <= d_n;
      off   <= off_n;
      q     <= q_n;
      done  <= done_n;
      exact <= exact_n;
      err   <= err_n;
    end
  end

endmodule

// File: tb/tb_gf2_exact_div_binomial.sv
// Bench for gf2_exact_div_binomial: vector table, random ops vs. polynomial model, corner sequences.
module tb_gf2_exact_div_binomial;

  localparam int N     = 16;
  localparam int LANES = 2;
  localparam int EW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [EW-1:0] a_exp = '0;
  logic [EW-1:0] b_exp = '0;
  logic [N-1:0]  p = '0;
  logic          busy, done, exact, err;
  logic [N-1:0]  q;

  int n_chk  = 0;
  int n_fail = 0;

  gf2_exact_div_binomial #(.N(N), .LANES(LANES), .EW(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_exp (a_exp),
    .b_exp (b_exp),
    .p     (p),
    .busy  (busy),
    .q     (q),
    .done  (done),
    .exact (exact),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  p;
    logic [EW-1:0] a;
    logic [EW-1:0] b;
    logic [N-1:0]  q;
    logic          ex;
    logic          er;
    int            cyc;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_valid(input int a, input int b);
    return (a > b) && (a < N);
  endfunction

  // Full carry-less product q*(x^a + x^b), no truncation.
  function automatic logic [63:0] m_mul(input logic [N-1:0] qq, input int a, input int b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (qq[i]) r = r ^ (64'd1 << (i + a)) ^ (64'd1 << (i + b));
    return r;
  endfunction

  function automatic logic [N-1:0] m_quot(input logic [N-1:0] pp, input int a, input int b);
    logic [N-1:0] r;
    r = '0;
    if (!m_valid(a, b)) return r;
    for (int s = a; s < N; s += (a - b)) r = r ^ (pp >> s);
    return r;
  endfunction

  function automatic int m_latency(input int a, input int b);
    int t;
    t = 0;
    if (!m_valid(a, b)) return 0;
    for (int s = a; s < N; s += (a - b)) t++;
    return (t + LANES - 1) / LANES + 1;
  endfunction

  // Launch one op and watch until done; cyc = edges after the accepting edge (-1 on timeout).
  task automatic run_op(input logic [N-1:0] pp, input logic [EW-1:0] a, input logic [EW-1:0] b,
                        output logic [N-1:0] rq, output logic rex, output logic rer,
                        output int cyc, output int bcnt);
    @(negedge clk);
    p = pp; a_exp = a; b_exp = b; start = 1'b1;
    @(posedge clk);
    cyc = -1; bcnt = 0; rq = '0; rex = 1'b0; rer = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        cyc = k; rq = q; rex = exact; rer = err;
        break;
      end
    end
  endtask

  task automatic do_and_check(input string tag, input logic [N-1:0] pp,
                              input logic [EW-1:0] a, input logic [EW-1:0] b);
    logic [N-1:0] rq, eq;
    logic rex, rer, eex;
    int cyc, bcnt, lat;
    eq  = m_quot(pp, int'(a), int'(b));
    eex = m_valid(int'(a), int'(b)) && (m_mul(eq, int'(a), int'(b)) == {48'd0, pp});
    lat = m_latency(int'(a), int'(b));
    run_op(pp, a, b, rq, rex, rer, cyc, bcnt);
    check({tag, ".q"},     32'(rq),  32'(eq));
    check({tag, ".exact"}, 32'(rex), 32'(eex));
    check({tag, ".err"},   32'(rer), 32'(!m_valid(int'(a), int'(b))));
    check({tag, ".lat"},   32'(cyc), 32'(lat));
    check({tag, ".busy"},  32'(bcnt), 32'(lat));
  endtask

  initial begin
    logic [N-1:0] rq, qq, pp;
    logic rex, rer;
    int cyc, bcnt, a, b, dcnt;
    int dk [$];
    logic [N-1:0] dq [$];
    logic dex [$];

    tbl[0] = '{16'h0036, 5'd4,  5'd1,  16'h0003, 1'b1, 1'b0, 3};
    tbl[1] = '{16'h003F, 5'd3,  5'd0,  16'h0007, 1'b1, 1'b0, 4};
    tbl[2] = '{16'h0001, 5'd4,  5'd1,  16'h0000, 1'b0, 1'b0, 3};
    tbl[3] = '{16'h0036, 5'd2,  5'd2,  16'h0000, 1'b0, 1'b1, 0};
    tbl[4] = '{16'h0036, 5'd16, 5'd1,  16'h0000, 1'b0, 1'b1, 0};
    tbl[5] = '{16'h0036, 5'd1,  5'd3,  16'h0000, 1'b0, 1'b1, 0};
    tbl[6] = '{16'hFFFF, 5'd15, 5'd14, 16'h0001, 1'b0, 1'b0, 2};
    tbl[7] = '{16'h0003, 5'd1,  5'd0,  16'h0001, 1'b1, 1'b0, 9};

    repeat (3) @(negedge clk);
    check("rst.q", 32'(q), 32'h0);
    check("rst.done", 32'(done), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.exact", 32'(exact), 32'h0);
    check("rst.err", 32'(err), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].p, tbl[i].a, tbl[i].b, rq, rex, rer, cyc, bcnt);
      check($sformatf("tbl%0d.q", i),     32'(rq),  32'(tbl[i].q));
      check($sformatf("tbl%0d.exact", i), 32'(rex), 32'(tbl[i].ex));
      check($sformatf("tbl%0d.err", i),   32'(rer), 32'(tbl[i].er));
      check($sformatf("tbl%0d.lat", i),   32'(cyc), 32'(tbl[i].cyc));
      check($sformatf("tbl%0d.busy", i),  32'(bcnt), 32'(tbl[i].er ? 0 : tbl[i].cyc));
    end

    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(0, 17));
      b = int'($urandom_range(0, 17));
      pp = 16'($urandom);
      if (m_valid(a, b) && ($urandom_range(0, 1) == 1)) begin
        qq = 16'($urandom) & 16'((32'd1 << (N - a)) - 1);
        pp = 16'(m_mul(qq, a, b));
      end
      do_and_check($sformatf("rnd%0d", i), pp, 5'(a), 5'(b));
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    p = 16'h0036; a_exp = 5'd4; b_exp = 5'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.q", 32'(q), 32'h0);
    check("midrst.busy", 32'(busy), 32'h0);
    check("midrst.done", 32'(done), 32'h0);
    dcnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst.nodone", 32'(dcnt), 32'h0);
    do_and_check("postrst", 16'h0036, 5'd4, 5'd1);

    // start held high: the second op is accepted only on the edge after done.
    @(negedge clk);
    p = 16'h0036; a_exp = 5'd4; b_exp = 5'd1; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2 || k == 4) check($sformatf("hold.busy%0d", k), 32'(busy), 32'h1);
      if (done) begin
        dk.push_back(k); dq.push_back(q); dex.push_back(exact);
      end
    end
    start = 1'b0;
    check("hold.ndone", 32'(dk.size()), 32'd2);
    if (dk.size() == 2) begin
      check("hold.done0", 32'(dk[0]), 32'd3);
      check("hold.done1", 32'(dk[1]), 32'd7);
      check("hold.q0", 32'(dq[0]), 32'h3);
      check("hold.q1", 32'(dq[1]), 32'h3);
      check("hold.ex0", 32'(dex[0]), 32'h1);
      check("hold.ex1", 32'(dex[1]), 32'h1);
    end
    repeat (6) @(negedge clk);
    check("hold.idle", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gf2_exact_div_binomial.md
Name: gf2_exact_div_binomial

Overview:
Sequential exact divider over GF(2)[x] for Toom-k interpolation: computes q = p / (x^A + x^B) for runtime-selected exponents A > B >= 0. It is the parametrised successor of the fixed x^4+x divider. It adds:
- runtime divisor selection
- LANES shift terms folded per cycle
- an explicit start/busy/done handshake
- a registered exactness check and a parameter error flag

It sits between the pointwise-product stage and the interpolation recombination network.

Parameters:
N, 4460, operand/quotient width in bits (coefficient i at bit i)
LANES, 2, shifted terms XOR-accumulated per RUN cycle (>=1)
EW, $clog2(N), width of exponent inputs

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only in IDLE
a_exp  in  EW  exponent A of divisor x^A+x^B
b_exp  in  EW  exponent B
p  in  N  dividend; captured at accepted start
busy  out  1  high in RUN and CHECK
q  out  N  quotient; valid from done until next accepted start
done  out  1  one-cycle pulse, result valid
exact  out  1  1 iff q*(x^A+x^B) == p; valid with done
err  out  1  1 iff parameters invalid; valid with done

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; q=0, done=0, busy=0, exact=0, err=0; internal p_reg=0, off=0, D=0.
- Math: D = A-B. q = XOR over k>=0 of (p >> (A + k*D)), with terms whose shift >= N omitted. This is exact when the divisor divides p; otherwise it is the quotient truncated from the top.
- Term count: T = ceil((N-A)/D). Cycle count: C = ceil(T/LANES).
- IDLE:
  - done deasserts after its one cycle.
  - start=1 with A>B and A<N: latch p_reg, A, B, D; set off=A; clear q, exact, err; go to RUN.
  - start=1 with A<=B or A>=N: q=0, exact=0, err=1, done=1 on the next edge; remain IDLE.
- RUN, each cycle:
  - q ^= XOR over j<LANES of (p_reg >> (off + j*D)), for lanes with off + j*D < N.
  - off += LANES*D.
  - If the new off >= N, go to CHECK.
  - Exactly C RUN cycles.
- off arithmetic: off is EW+1 bits wide plus saturation; it must never wrap. With off >= N, all lanes contribute 0.
- CHECK (1 cycle): exact <= (((q<<A) ^ (q<<B)) truncated to N bits == p_reg) AND (q >> (N-A) == 0). Then done <= 1, go to IDLE.
- Latency: start accepted at edge 0; done high after edge C+1; busy high for C+1 cycles.
- start while busy: ignored, with no effect on the operation in flight.
- start in the same cycle done is high: accepted normally. q clears on the next edge.
- rst_n low mid-operation: immediately returns all state to reset values; no done pulse.
- q is stable outside RUN; bench reads it only when done=1.

Decomposition:
- Package gf2_div_pkg:
  - state enum {IDLE, RUN, CHECK}
  - function f_terms(N, A, D) for the bench latency model
  - localparam for off width
- Sub-module gf2_shift_xor_lanes: combinational. Inputs p_reg, off, D. Output is the LANES-term XOR. Instantiated once.

Test Plan:
- Test parameters for all scenarios: N=16, LANES=2.
- p=0x0036, A=4, B=1 -> q=0x0003, exact=1, err=0; done 3 cycles after start (C=2).
- p=0x003F, A=3, B=0 -> q=0x0007, exact=1; done 4 cycles after start (C=3).
- p=0x0001, A=4, B=1 -> q=0x0000, exact=0, err=0.
- A=2, B=2 (and separately A=16) -> done 1 cycle after start, err=1, q=0, busy never high.
- Start accepted, rst_n pulled low during RUN cycle 1 -> q=0, busy=0, no done. A fresh start with p=0x0036, A=4, B=1 yields q=0x0003.
- start held high throughout the 0x0036 operation -> second operation accepted only in the done cycle. Back-to-back results are identical.
